icache_ctrl: RTL and testbench

//  Direct-mapped instruction cache + controller between inst_fetcher and mem_ctrl.

---
 rtl/icache_ctrl.sv | 178 +++++++++++++++++
 tb/tb_icache_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// ----------------------------------------------------------------------------
// icache_ctrl
//    Direct-mapped, one-word-per-line instruction cache sitting between the
//    instruction fetcher (IF channel) and the memory controller (MC channel).
//    Hits answer in one cycle from the local arrays; misses issue a single
//    word fetch to the memory controller, fill the line, then answer IF.
//
// Parameters
//    IDX_WD           index bits; 2**IDX_WD one-word lines
//
// Ports
//    clk              clock
//    rst              synchronous active-high reset
//    rdy              0 = freeze all state, arrays, counters and outputs
//    jump_wrong_flag  mispredict flush: abort any outstanding request
//    IF_req           fetch request (level, held until IF_flag)
//    IF_addr          fetch pc, word aligned
//    IF_flag          one-cycle pulse, IF_inst valid
//    IF_inst          instruction for the accepted IF_addr
//    MC_req           miss request to memory controller (level, held until MC_flag)
//    MC_addr          miss address, word aligned
//    MC_flag          one-cycle pulse, MC_inst valid
//    MC_inst          fetched word
//    hit_cnt          hits since reset
//    miss_cnt         misses since reset
// ----------------------------------------------------------------------------
module icache_ctrl #(
   parameter int unsigned IDX_WD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_wrong_flag,
   input  logic        IF_req,
   input  logic [31:0] IF_addr,
   output logic        IF_flag,
   output logic [31:0] IF_inst,
   output logic        MC_req,
   output logic [31:0] MC_addr,
   input  logic        MC_flag,
   input  logic [31:0] MC_inst,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int unsigned LINES  = 2 ** IDX_WD;
   localparam int unsigned TAG_WD = 30 - IDX_WD;

   typedef enum logic {
      IDLE,
      MISS
   } state_t;

   state_t state, state_nxt;

   logic [31:0]       data_arr [LINES];
   logic [TAG_WD-1:0] tag_arr  [LINES];
   logic [LINES-1:0]  valid;

   logic [IDX_WD-1:0] req_idx, fill_idx;
   logic [TAG_WD-1:0] req_tag, fill_tag;
   logic              hit, accept, fill_en;

   logic              if_flag_nxt, mc_req_nxt, hit_inc, miss_inc;
   logic [31:0]       if_inst_nxt, mc_addr_nxt;

   // Byte offset of the fetch pc carries no information for a word cache.
   logic              addr_lo_unused;
   assign addr_lo_unused = ^IF_addr[1:0];

   assign req_idx  = IF_addr[IDX_WD+1:2];
   assign req_tag  = IF_addr[31:IDX_WD+2];
   // Fill location comes from the latched miss address, since IF_addr may
   // already have moved on (e.g. after a flush) by the time data returns.
   assign fill_idx = MC_addr[IDX_WD+1:2];
   assign fill_tag = MC_addr[31:IDX_WD+2];

   assign hit     = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign accept  = IF_req && !IF_flag && !jump_wrong_flag;
   // A returning word is written even when a flush coincides with it: the
   // data is still correct for MC_addr, only the answer to IF is dropped.
   assign fill_en = (state == MISS) && MC_flag;

   // ------------------------------------------------------------------------
   // State, output and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         IF_flag  <= 1'b0;
         IF_inst  <= '0;
         MC_req   <= 1'b0;
         MC_addr  <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
         valid    <= '0;
      end else if (rdy) begin
         state   <= state_nxt;
         IF_flag <= if_flag_nxt;
         IF_inst <= if_inst_nxt;
         MC_req  <= mc_req_nxt;
         MC_addr <= mc_addr_nxt;
         if (hit_inc)
            hit_cnt <= hit_cnt + 32'd1;
         if (miss_inc)
            miss_cnt <= miss_cnt + 32'd1;
         if (fill_en)
            valid[fill_idx] <= 1'b1;
      end
   end

   // Data/tag storage carries no reset so it maps onto distributed RAM;
   // the valid vector alone defines which lines are meaningful.
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill_en) begin
         data_arr[fill_idx] <= MC_inst;
         tag_arr[fill_idx]  <= fill_tag;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      if (jump_wrong_flag) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (accept && !hit) state_nxt = MISS;
            MISS: if (MC_flag)        state_nxt = IDLE;
            default:                  state_nxt = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output logic: next values of the registered outputs
   // ------------------------------------------------------------------------
   always_comb begin
      if_flag_nxt = 1'b0;
      if_inst_nxt = IF_inst;
      mc_req_nxt  = MC_req;
      mc_addr_nxt = MC_addr;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      if (jump_wrong_flag) begin
         mc_req_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (hit) begin
                     if_flag_nxt = 1'b1;
                     if_inst_nxt = data_arr[req_idx];
                     hit_inc     = 1'b1;
                  end else begin
                     mc_req_nxt  = 1'b1;
                     mc_addr_nxt = {IF_addr[31:2], 2'b00};
                     miss_inc    = 1'b1;
                  end
               end
            end
            MISS: begin
               if (MC_flag) begin
                  mc_req_nxt  = 1'b0;
                  if_flag_nxt = 1'b1;
                  if_inst_nxt = MC_inst;
               end
            end
            default: begin
               mc_req_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_icache_ctrl
//    Directed bench for icache_ctrl. The bench plays both the fetcher and the
//    memory controller. Expected instructions are queued when a fetch is
//    issued and popped when IF_flag is observed.
// ----------------------------------------------------------------------------
module tb_icache_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_wrong_flag;
   logic        IF_req;
   logic [31:0] IF_addr;
   logic        IF_flag;
   logic [31:0] IF_inst;
   logic        MC_req;
   logic [31:0] MC_addr;
   logic        MC_flag;
   logic [31:0] MC_inst;
   logic [31:0] hit_cnt, miss_cnt;

   int          total = 0;
   int          bad   = 0;
   int unsigned exp_hit  = 0;
   int unsigned exp_miss = 0;
   logic [31:0] sb_q [$];

   icache_ctrl #(.IDX_WD(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .jump_wrong_flag (jump_wrong_flag),
      .IF_req          (IF_req),
      .IF_addr         (IF_addr),
      .IF_flag         (IF_flag),
      .IF_inst         (IF_inst),
      .MC_req          (MC_req),
      .MC_addr         (MC_addr),
      .MC_flag         (MC_flag),
      .MC_inst         (MC_inst),
      .hit_cnt         (hit_cnt),
      .miss_cnt        (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      total++;
      assert (sb_q.size() != 0) else begin
         bad++;
         $error("FAIL %s_sb observed=%0d expected=nonempty", tag, sb_q.size());
      end
      if (sb_q.size() != 0)
         check(tag, IF_inst, sb_q.pop_front());
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_hits"},   hit_cnt,  exp_hit);
      check({tag, "_misses"}, miss_cnt, exp_miss);
   endtask

   // Fetch that must miss; memory returns data after lat cycles of MC_req.
   task automatic miss_fetch(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input int unsigned lat);
      IF_req  = 1'b1;
      IF_addr = addr;
      sb_q.push_back(data);
      exp_miss++;
      tick();
      check({tag, "_mcreq"},  MC_req,  1'b1);
      check({tag, "_mcaddr"}, MC_addr, {addr[31:2], 2'b00});
      for (int unsigned i = 1; i < lat; i++) begin
         tick();
         check({tag, "_hold"},  MC_req,  1'b1);
         check({tag, "_noif"},  IF_flag, 1'b0);
      end
      MC_flag = 1'b1;
      MC_inst = data;
      tick();
      MC_flag = 1'b0;
      MC_inst = '0;
      check({tag, "_ifflag"}, IF_flag, 1'b1);
      check({tag, "_mcdrop"}, MC_req,  1'b0);
      if (IF_flag === 1'b1)
         pop_check({tag, "_inst"});
      IF_req = 1'b0;
      tick();
      check({tag, "_pulse"}, IF_flag, 1'b0);
   endtask

   // Fetch that must hit: IF_flag one cycle later, no memory traffic.
   task automatic hit_fetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] data);
      IF_req  = 1'b1;
      IF_addr = addr;
      sb_q.push_back(data);
      exp_hit++;
      tick();
      check({tag, "_ifflag"}, IF_flag, 1'b1);
      check({tag, "_mcreq"},  MC_req,  1'b0);
      if (IF_flag === 1'b1)
         pop_check({tag, "_inst"});
      IF_req = 1'b0;
      tick();
      check({tag, "_pulse"}, IF_flag, 1'b0);
   endtask

   initial begin
      rst             = 1'b1;
      rdy             = 1'b1;
      jump_wrong_flag = 1'b0;
      IF_req          = 1'b0;
      IF_addr         = '0;
      MC_flag         = 1'b0;
      MC_inst         = '0;
      repeat (3) tick();
      check("rst_ifflag", IF_flag, 1'b0);
      check("rst_ifinst", IF_inst, 32'h0);
      check("rst_mcreq",  MC_req,  1'b0);
      check("rst_mcaddr", MC_addr, 32'h0);
      check_cnts("rst");
      rst = 1'b0;
      tick();

      // Cold miss, then hit on the same line.
      miss_fetch("cold", 32'h0000_0000, 32'h0000_0013, 3);
      check_cnts("cold");
      hit_fetch("hit0", 32'h0000_0000, 32'h0000_0013);
      check_cnts("hit0");

      // Conflict on index 0: new tag evicts, original misses again.
      miss_fetch("conf400", 32'h0000_0400, 32'h0010_0093, 2);
      miss_fetch("conf0",   32'h0000_0000, 32'h0000_0013, 1);
      check_cnts("conflict");
      hit_fetch("hit400miss", 32'h0000_0000, 32'h0000_0013);

      // Flush while the miss is outstanding.
      IF_req  = 1'b1;
      IF_addr = 32'h0000_0008;
      exp_miss++;
      tick();
      check("flm_mcreq", MC_req, 1'b1);
      jump_wrong_flag = 1'b1;
      IF_req          = 1'b0;
      tick();
      jump_wrong_flag = 1'b0;
      check("flm_mcdrop", MC_req,  1'b0);
      check("flm_noif",   IF_flag, 1'b0);
      // Late memory response in IDLE must not fill the line.
      MC_flag = 1'b1;
      MC_inst = 32'h1111_1111;
      tick();
      MC_flag = 1'b0;
      MC_inst = '0;
      check("late_noif", IF_flag, 1'b0);
      check_cnts("flm");

      // Re-fetch misses afresh; flush coincides with the returning word.
      IF_req  = 1'b1;
      IF_addr = 32'h0000_0008;
      exp_miss++;
      tick();
      check("flc_mcreq", MC_req, 1'b1);
      MC_flag         = 1'b1;
      MC_inst         = 32'hDEAD_BEEF;
      jump_wrong_flag = 1'b1;
      IF_req          = 1'b0;
      tick();
      MC_flag         = 1'b0;
      MC_inst         = '0;
      jump_wrong_flag = 1'b0;
      check("flc_noif",   IF_flag, 1'b0);
      check("flc_mcdrop", MC_req,  1'b0);
      tick();
      check("flc_noif2",  IF_flag, 1'b0);
      hit_fetch("flc_hit", 32'h0000_0008, 32'hDEAD_BEEF);
      check_cnts("flc");

      // Request presented in a flush cycle is not accepted.
      IF_req          = 1'b1;
      IF_addr         = 32'h0000_0000;
      jump_wrong_flag = 1'b1;
      tick();
      jump_wrong_flag = 1'b0;
      check("jwf_block", IF_flag, 1'b0);
      check_cnts("jwf_block");
      hit_fetch("jwf_after", 32'h0000_0000, 32'h0000_0013);

      // Stall while IF_flag is high: pulse and data hold, counters frozen.
      IF_req  = 1'b1;
      IF_addr = 32'h0000_0000;
      sb_q.push_back(32'h0000_0013);
      exp_hit++;
      tick();
      check("stall_ifflag", IF_flag, 1'b1);
      if (IF_flag === 1'b1)
         pop_check("stall_inst");
      IF_req = 1'b0;
      rdy    = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         tick();
         check("stall_hold",  IF_flag, 1'b1);
         check("stall_ihold", IF_inst, 32'h0000_0013);
         check_cnts("stall");
      end
      rdy = 1'b1;
      tick();
      check("stall_resume", IF_flag, 1'b0);
      check_cnts("stall_end");

      // Reset in the middle of a miss.
      IF_req  = 1'b1;
      IF_addr = 32'h0000_0100;
      tick();
      check("rmm_mcreq", MC_req, 1'b1);
      rst    = 1'b1;
      IF_req = 1'b0;
      tick();
      rst      = 1'b0;
      exp_hit  = 0;
      exp_miss = 0;
      check("rmm_mcdrop", MC_req, 1'b0);
      check_cnts("rmm");
      MC_flag = 1'b1;
      MC_inst = 32'h5555_5555;
      tick();
      MC_flag = 1'b0;
      MC_inst = '0;
      check("rmm_noif", IF_flag, 1'b0);
      miss_fetch("rmm_refetch", 32'h0000_0100, 32'h0000_0077, 2);
      check_cnts("rmm_end");

      check("sb_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
